// File: rtl/fx_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// fx_ctrl_fsm
//
// Front-panel controller for the effect chain. Sequences the mode FSM
// (init, play, set, loop record, loop play), owns the per-effect parameter
// registers, edge-detects the panel keys and generates address/strobe timing
// for the SRAM looper.
//
// Build option:
//   FX_CTRL_SAT_EN  defined   -> a val press at the maximum parameter value
//                                holds the maximum.
//                   undefined -> a val press at the maximum wraps to 0.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_i2c_done     codec init finished (level)
//   i_key_val      change-value key (level)
//   i_key_loop     record/play-loop key (level)
//   i_key_mode     set/play mode key (level)
//   i_sel          selected effect index
//   i_en           effect enable switches
//   i_sample_tick  one-cycle pulse per audio sample
//   o_state        FSM state code
//   o_params       packed parameters, effect k at [k*PW +: PW]
//   o_cur_val      parameter of i_sel while in SET, else 0 (combinational)
//   o_ledg         state indicator LEDs
//   o_ledr         effect indicator LEDs (combinational)
//   o_loop_addr    loop memory address
//   o_loop_wr      loop write strobe
//   o_loop_rd      loop read strobe
//   o_loop_len     captured loop length in samples
//
// state | meaning
// ------+--------------------------------------------------------------
// INIT  | waiting for codec init to finish
// PLAY  | live playback, effects follow the enable switches
// SET   | editing the parameter of the selected effect
// RECD  | recording one sample per tick into loop memory
// LOOP  | replaying the captured loop, one sample per tick
// ---------------------------------------------------------------------------
module fx_ctrl_fsm #(
  parameter int N_FX    = 8,
  parameter int PW      = 3,
  parameter int SEL_W   = $clog2(N_FX),
  parameter int LOOP_AW = 20
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_i2c_done,
  input  logic                 i_key_val,
  input  logic                 i_key_loop,
  input  logic                 i_key_mode,
  input  logic [SEL_W-1:0]     i_sel,
  input  logic [N_FX-1:0]      i_en,
  input  logic                 i_sample_tick,
  output logic [2:0]           o_state,
  output logic [N_FX*PW-1:0]   o_params,
  output logic [PW-1:0]        o_cur_val,
  output logic [8:0]           o_ledg,
  output logic [N_FX-1:0]      o_ledr,
  output logic [LOOP_AW-1:0]   o_loop_addr,
  output logic                 o_loop_wr,
  output logic                 o_loop_rd,
  output logic [LOOP_AW:0]     o_loop_len
);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_PLAY = 3'd1,
    ST_SET  = 3'd2,
    ST_RECD = 3'd3,
    ST_LOOP = 3'd4
  } state_t;

  localparam logic [LOOP_AW:0]   DEPTH_LEN = {1'b1, {LOOP_AW{1'b0}}};
  localparam logic [LOOP_AW-1:0] LAST_SLOT = {LOOP_AW{1'b1}};
  localparam logic [PW-1:0]      PARAM_MAX = {PW{1'b1}};

  // registered state
  state_t               state_q,    state_d;
  logic [PW-1:0]        param_q [N_FX];
  logic [PW-1:0]        param_d [N_FX];
  logic [LOOP_AW-1:0]   addr_q,     addr_d;
  logic [LOOP_AW:0]     len_q,      len_d;
  logic                 wr_q,       wr_d;
  logic                 rd_q,       rd_d;
  logic [8:0]           ledg_q,     ledg_d;
  logic                 key_val_q,  key_val_d;
  logic                 key_loop_q, key_loop_d;
  logic                 key_mode_q, key_mode_d;

  logic                 val_press;
  logic                 loop_press;
  logic                 mode_press;
  logic [LOOP_AW:0]     rec_count;
  logic [LOOP_AW:0]     rd_next;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] v);
`ifdef FX_CTRL_SAT_EN
    return (v == PARAM_MAX) ? v : v + PW'(1);
`else
    return v + PW'(1);
`endif
  endfunction

  always_comb begin
    val_press  = i_key_val  & ~key_val_q;
    loop_press = i_key_loop & ~key_loop_q;
    mode_press = i_key_mode & ~key_mode_q;

    key_val_d  = i_key_val;
    key_loop_d = i_key_loop;
    key_mode_d = i_key_mode;

    // Samples written so far, counting a write whose strobe is high this
    // cycle (its address advance has not happened yet).
    rec_count = {1'b0, addr_q} + {{LOOP_AW{1'b0}}, wr_q};
    rd_next   = {1'b0, addr_q} + {{LOOP_AW{1'b0}}, 1'b1};

    state_d = state_q;
    param_d = param_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (i_i2c_done) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (mode_press) begin
          state_d = ST_SET;
        end else if (loop_press) begin
          state_d = ST_RECD;
          addr_d  = '0;
          len_d   = '0;
        end
      end

      ST_SET: begin
        if (mode_press) state_d = ST_PLAY;
        // Out-of-range selectors match no k and leave every parameter alone.
        if (val_press) begin
          for (int k = 0; k < N_FX; k++) begin
            if (i_sel == SEL_W'(k)) param_d[k] = bump(param_q[k]);
          end
        end
      end

      ST_RECD: begin
        if (wr_q) addr_d = addr_q + LOOP_AW'(1);
        if (wr_q && addr_q == LAST_SLOT) begin
          // memory full: the loop is the whole depth
          state_d = ST_LOOP;
          len_d   = DEPTH_LEN;
          addr_d  = '0;
        end else if (loop_press) begin
          addr_d = '0;
          len_d  = rec_count;
          state_d = (rec_count == '0) ? ST_PLAY : ST_LOOP;
        end else if (i_sample_tick) begin
          wr_d = 1'b1;
        end
      end

      ST_LOOP: begin
        if (rd_q) addr_d = (rd_next == len_q) ? '0 : addr_q + LOOP_AW'(1);
        if (loop_press) begin
          state_d = ST_PLAY;
          addr_d  = '0;
        end else if (i_sample_tick) begin
          rd_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    case (state_d)
      ST_PLAY: ledg_d = 9'h001;
      ST_SET:  ledg_d = 9'h002;
      ST_RECD: ledg_d = 9'h004;
      ST_LOOP: ledg_d = 9'h008;
      default: ledg_d = 9'h100;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_INIT;
      for (int k = 0; k < N_FX; k++) param_q[k] <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      ledg_q     <= 9'h100;
      key_val_q  <= 1'b0;
      key_loop_q <= 1'b0;
      key_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      param_q    <= param_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ledg_q     <= ledg_d;
      key_val_q  <= key_val_d;
      key_loop_q <= key_loop_d;
      key_mode_q <= key_mode_d;
    end
  end

  always_comb begin
    o_params  = '0;
    o_cur_val = '0;
    o_ledr    = i_en;
    for (int k = 0; k < N_FX; k++) o_params[k*PW +: PW] = param_q[k];
    if (state_q == ST_SET) begin
      o_ledr = '0;
      for (int k = 0; k < N_FX; k++) begin
        if (i_sel == SEL_W'(k)) begin
          o_ledr[k] = 1'b1;
          o_cur_val = param_q[k];
        end
      end
    end
  end

  assign o_state     = state_q;
  assign o_ledg      = ledg_q;
  assign o_loop_addr = addr_q;
  assign o_loop_wr   = wr_q;
  assign o_loop_rd   = rd_q;
  assign o_loop_len  = len_q;

endmodule

// File: tb/tb_fx_ctrl_fsm.sv
module tb_fx_ctrl_fsm;

  localparam int N_FX    = 6;
  localparam int PW      = 3;
  localparam int SEL_W   = 3;
  localparam int LOOP_AW = 3;

  logic                 i_clk;
  logic                 i_rst;
  logic                 i_i2c_done;
  logic                 i_key_val;
  logic                 i_key_loop;
  logic                 i_key_mode;
  logic [SEL_W-1:0]     i_sel;
  logic [N_FX-1:0]      i_en;
  logic                 i_sample_tick;
  logic [2:0]           o_state;
  logic [N_FX*PW-1:0]   o_params;
  logic [PW-1:0]        o_cur_val;
  logic [8:0]           o_ledg;
  logic [N_FX-1:0]      o_ledr;
  logic [LOOP_AW-1:0]   o_loop_addr;
  logic                 o_loop_wr;
  logic                 o_loop_rd;
  logic [LOOP_AW:0]     o_loop_len;

  int total = 0;
  int bad   = 0;

  // expected strobes: {wr, rd, addr}
  logic [LOOP_AW+1:0] exp_q[$];

  fx_ctrl_fsm #(
    .N_FX(N_FX), .PW(PW), .SEL_W(SEL_W), .LOOP_AW(LOOP_AW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_i2c_done(i_i2c_done),
    .i_key_val(i_key_val), .i_key_loop(i_key_loop), .i_key_mode(i_key_mode),
    .i_sel(i_sel), .i_en(i_en), .i_sample_tick(i_sample_tick),
    .o_state(o_state), .o_params(o_params), .o_cur_val(o_cur_val),
    .o_ledg(o_ledg), .o_ledr(o_ledr), .o_loop_addr(o_loop_addr),
    .o_loop_wr(o_loop_wr), .o_loop_rd(o_loop_rd), .o_loop_len(o_loop_len)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // strobe scoreboard: every strobe seen must match the next expected entry
  always @(negedge i_clk) begin
    if (o_loop_wr || o_loop_rd) begin
      logic [LOOP_AW+1:0] got;
      logic [LOOP_AW+1:0] want;
      got = {o_loop_wr, o_loop_rd, o_loop_addr};
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL strobe_unexpected got=%b exp=none", got);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        total++;
        assert (got === want) else begin
          bad++;
          $error("FAIL strobe got=%b exp=%b", got, want);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // which: 0=val 1=loop 2=mode
  task automatic press(input int which, input int hold);
    case (which)
      0: i_key_val  = 1'b1;
      1: i_key_loop = 1'b1;
      default: i_key_mode = 1'b1;
    endcase
    cyc(hold);
    i_key_val  = 1'b0;
    i_key_loop = 1'b0;
    i_key_mode = 1'b0;
    cyc(1);
  endtask

  task automatic tick();
    i_sample_tick = 1'b1;
    cyc(1);
    i_sample_tick = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic [PW-1:0]      exp_v;
    logic [N_FX*PW-1:0] exp_params;

    i_rst = 1'b1; i_i2c_done = 1'b0; i_key_val = 1'b0; i_key_loop = 1'b0;
    i_key_mode = 1'b0; i_sel = '0; i_en = '0; i_sample_tick = 1'b0;
    cyc(3);
    chk("rst_state",  32'(o_state), 32'd0);
    chk("rst_ledg",   32'(o_ledg), 32'h100);
    chk("rst_params", 32'(o_params), 32'd0);
    chk("rst_addr",   32'(o_loop_addr), 32'd0);
    chk("rst_len",    32'(o_loop_len), 32'd0);
    chk("rst_strobe", 32'({o_loop_wr, o_loop_rd}), 32'd0);

    i_rst = 1'b0;
    cyc(1);
    chk("init_hold", 32'(o_state), 32'd0);
    i_i2c_done = 1'b1;
    cyc(1);
    chk("play_state", 32'(o_state), 32'd1);
    chk("play_ledg",  32'(o_ledg), 32'h001);

    // SET: nine held val presses on effect 2
    press(2, 1);
    chk("set_state", 32'(o_state), 32'd2);
    chk("set_ledg",  32'(o_ledg), 32'h002);
    i_sel = 3'd2;
    #1;
    chk("set_ledr", 32'(o_ledr), 32'b000100);
    chk("set_cur0", 32'(o_cur_val), 32'd0);
    exp_v = '0;
    for (int n = 0; n < 9; n++) begin
      i_key_val = 1'b1;
      cyc(1);
`ifdef FX_CTRL_SAT_EN
      exp_v = (exp_v == 3'd7) ? 3'd7 : exp_v + 3'd1;
`else
      exp_v = exp_v + 3'd1;
`endif
      chk("cur_val_edge", 32'(o_cur_val), 32'(exp_v));
      cyc(4);
      chk("cur_val_held", 32'(o_cur_val), 32'(exp_v));
      i_key_val = 1'b0;
      cyc(1);
    end
`ifdef FX_CTRL_SAT_EN
    chk("param2_final", 32'(exp_v), 32'd7);
`else
    chk("param2_final", 32'(o_cur_val), 32'd1);
`endif
    exp_params = '0;
    exp_params[2*PW +: PW] = exp_v;
    chk("params_after_set", 32'(o_params), 32'(exp_params));

    // out-of-range selector
    i_sel = 3'd7;
    #1;
    chk("oor_ledr", 32'(o_ledr), 32'd0);
    chk("oor_cur",  32'(o_cur_val), 32'd0);
    press(0, 1);
    chk("oor_params", 32'(o_params), 32'(exp_params));
    press(1, 1);
    chk("set_loop_ignored", 32'(o_state), 32'd2);

    press(2, 1);
    chk("back_play", 32'(o_state), 32'd1);
    i_en = 6'h2A;
    i_sel = 3'd2;
    #1;
    chk("play_ledr", 32'(o_ledr), 32'h2A);
    chk("play_cur",  32'(o_cur_val), 32'd0);
    press(0, 1);
    chk("play_val_ignored", 32'(o_params), 32'(exp_params));

    // record 5, replay 7
    press(1, 1);
    chk("recd_state", 32'(o_state), 32'd3);
    chk("recd_ledg",  32'(o_ledg), 32'h004);
    chk("recd_len0",  32'(o_loop_len), 32'd0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({1'b1, 1'b0, 3'(i)});
      tick();
    end
    chk("recd_addr5", 32'(o_loop_addr), 32'd5);
    press(1, 1);
    chk("loop_state", 32'(o_state), 32'd4);
    chk("loop_ledg",  32'(o_ledg), 32'h008);
    chk("loop_len5",  32'(o_loop_len), 32'd5);
    chk("loop_addr0", 32'(o_loop_addr), 32'd0);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({1'b0, 1'b1, 3'(i % 5)});
      tick();
    end
    chk("q_empty_a", 32'(exp_q.size()), 32'd0);
    press(2, 1);
    press(0, 1);
    chk("loop_mode_ignored", 32'(o_state), 32'd4);
    chk("loop_params", 32'(o_params), 32'(exp_params));
    press(1, 1);
    chk("loop_exit", 32'(o_state), 32'd1);
    chk("loop_exit_len", 32'(o_loop_len), 32'd5);
    chk("loop_exit_addr", 32'(o_loop_addr), 32'd0);

    // fill the whole memory: automatic LOOP entry
    press(1, 1);
    chk("recd2_len0", 32'(o_loop_len), 32'd0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({1'b1, 1'b0, 3'(i)});
      tick();
    end
    chk("auto_state", 32'(o_state), 32'd4);
    chk("auto_len",   32'(o_loop_len), 32'd8);
    chk("auto_addr",  32'(o_loop_addr), 32'd0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 1'b1, 3'(i)});
      tick();
    end
    // press coincident with tick: no strobe
    i_key_loop = 1'b1; i_sample_tick = 1'b1;
    cyc(1);
    i_key_loop = 1'b0; i_sample_tick = 1'b0;
    cyc(1);
    chk("coinc_state",  32'(o_state), 32'd1);
    chk("coinc_strobe", 32'({o_loop_wr, o_loop_rd}), 32'd0);
    chk("coinc_len",    32'(o_loop_len), 32'd8);
    chk("q_empty_b", 32'(exp_q.size()), 32'd0);

    // simultaneous mode + loop in PLAY
    i_key_mode = 1'b1; i_key_loop = 1'b1;
    cyc(1);
    i_key_mode = 1'b0; i_key_loop = 1'b0;
    cyc(1);
    chk("simul_set", 32'(o_state), 32'd2);
    press(2, 1);
    chk("simul_back", 32'(o_state), 32'd1);

    // zero-length record
    press(1, 1);
    chk("zero_recd", 32'(o_state), 32'd3);
    press(1, 1);
    chk("zero_play", 32'(o_state), 32'd1);
    chk("zero_len",  32'(o_loop_len), 32'd0);

    // reset in the middle of a record, strobe high at the reset edge
    press(1, 1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b1, 1'b0, 3'(i)});
      tick();
    end
    exp_q.push_back({1'b1, 1'b0, 3'd3});
    i_sample_tick = 1'b1;
    cyc(1);
    i_sample_tick = 1'b0;
    i_rst = 1'b1;
    cyc(1);
    chk("mrst_state",  32'(o_state), 32'd0);
    chk("mrst_strobe", 32'({o_loop_wr, o_loop_rd}), 32'd0);
    chk("mrst_len",    32'(o_loop_len), 32'd0);
    chk("mrst_addr",   32'(o_loop_addr), 32'd0);
    chk("mrst_ledg",   32'(o_ledg), 32'h100);
    chk("mrst_params", 32'(o_params), 32'd0);
    i_rst = 1'b0;
    cyc(2);
    chk("q_empty_end", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
